// File: rtl/cape_apb_uart_pkg.sv
// Shared definitions for the cape APB UART: register selectors, bit positions,
// baud floor and the FSM state type used by both the TX and RX engines.
package cape_apb_uart_pkg;

  // Register selectors, decoded from paddr[3:2]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;
  localparam logic [1:0] REG_IRQ_EN = 2'd3;

  // STATUS bit positions
  localparam int unsigned ST_TX_FULL  = 0;
  localparam int unsigned ST_TX_EMPTY = 1;
  localparam int unsigned ST_RX_EMPTY = 2;
  localparam int unsigned ST_RX_FULL  = 3;
  localparam int unsigned ST_RX_OVR   = 4;
  localparam int unsigned ST_FRM_ERR  = 5;
  localparam int unsigned ST_TX_BUSY  = 6;
  localparam int unsigned ST_TX_CNT   = 8;
  localparam int unsigned ST_RX_CNT   = 12;

  // IRQ_EN bit positions
  localparam int unsigned IE_RX_NE    = 0;
  localparam int unsigned IE_TX_EMPTY = 1;
  localparam int unsigned IE_ERR      = 2;

  localparam logic [15:0] BAUD_MIN = 16'd15;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_state_e;

  // Very small divisors would leave no room for the mid-bit sample point
  function automatic logic [15:0] clamp_baud(input logic [15:0] v);
    return (v < BAUD_MIN) ? BAUD_MIN : v;
  endfunction

  // A 16-deep FIFO reports 16 entries; the 4-bit STATUS field shows 15 then
  function automatic logic [3:0] sat_cnt4(input logic [4:0] c);
    return (c > 5'd15) ? 4'hF : c[3:0];
  endfunction

endpackage

// File: rtl/cape_apb_uart_if.sv
// APB slave-side bundle for the cape UART (no pready: zero wait states).
interface cape_apb_uart_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  modport master (output psel, penable, pwrite, paddr, pwdata, input prdata);
  modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. A full FIFO accepts a push only
// when a real pop happens in the same cycle; an empty FIFO never pops.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Storage array; contents need no reset since pointers define validity
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers wrap naturally (power-of-two depth); count tracks occupancy
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/cape_apb_uart.sv
// APB-mapped 8N1 UART for one cape channel: TX/RX FIFOs, programmable baud
// divider, sticky RX error flags and a registered level interrupt.
module cape_apb_uart
  import cape_apb_uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned BAUD_DIV_RST = 541
) (
  input  logic           pclk,
  input  logic           presetn,
  cape_apb_uart_if.slave apb,
  input  logic           rxd,
  output logic           txd,
  output logic           txd_oe,
  output logic           irq
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic        acc, wr_acc;
  logic [1:0]  reg_sel;
  logic [15:0] baud_q;
  logic [2:0]  irq_en_q;
  logic        ovr_q, ferr_q, irq_q;
  logic [15:0] status;
  logic        unused_bits;

  // FIFO wiring
  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]    tx_rdata;
  logic [CW-1:0] tx_count;
  logic          rx_push, rx_pop, rx_pop_ok, rx_full, rx_empty;
  logic [7:0]    rx_rdata;
  logic [CW-1:0] rx_count;

  // TX engine
  uart_state_e tx_state_q;
  logic [15:0] tx_cnt_q;
  logic [7:0]  tx_sh_q;
  logic [2:0]  tx_bit_q;
  logic        txd_q;

  // RX engine
  uart_state_e rx_state_q;
  logic [15:0] rx_cnt_q;
  logic [7:0]  rx_sh_q;
  logic [2:0]  rx_bit_q;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic [16:0] rx_half;
  logic [15:0] rx_half_m1;
  logic        rx_stop_smp, ferr_set, ovr_set;

  assign acc         = apb.psel & apb.penable;
  assign wr_acc      = acc & apb.pwrite;
  assign reg_sel     = apb.paddr[3:2];
  assign unused_bits = ^{apb.paddr[7:4], apb.paddr[1:0], apb.pwdata[31:16]};

  assign tx_push   = wr_acc & (reg_sel == REG_DATA);
  assign rx_pop    = acc & ~apb.pwrite & (reg_sel == REG_DATA);
  assign rx_pop_ok = rx_pop & ~rx_empty;

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (pclk),
    .rst_ni  (presetn),
    .push_i  (tx_push),
    .wdata_i (apb.pwdata[7:0]),
    .pop_i   (tx_pop),
    .rdata_o (tx_rdata),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i   (pclk),
    .rst_ni  (presetn),
    .push_i  (rx_push),
    .wdata_i (rx_sh_q),
    .pop_i   (rx_pop),
    .rdata_o (rx_rdata),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  // Control registers: divisor and interrupt enables
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      baud_q   <= 16'(BAUD_DIV_RST);
      irq_en_q <= '0;
    end else if (wr_acc) begin
      if (reg_sel == REG_BAUD)   baud_q   <= clamp_baud(apb.pwdata[15:0]);
      if (reg_sel == REG_IRQ_EN) irq_en_q <= apb.pwdata[2:0];
    end
  end

  // Sticky error flags; a new event beats a simultaneous W1C
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ovr_q  <= ovr_set  | (ovr_q  & ~(wr_acc & (reg_sel == REG_STATUS) & apb.pwdata[ST_RX_OVR]));
      ferr_q <= ferr_set | (ferr_q & ~(wr_acc & (reg_sel == REG_STATUS) & apb.pwdata[ST_FRM_ERR]));
    end
  end

  // STATUS word assembly
  always_comb begin
    status                  = '0;
    status[ST_TX_FULL]      = tx_full;
    status[ST_TX_EMPTY]     = tx_empty;
    status[ST_RX_EMPTY]     = rx_empty;
    status[ST_RX_FULL]      = rx_full;
    status[ST_RX_OVR]       = ovr_q;
    status[ST_FRM_ERR]      = ferr_q;
    status[ST_TX_BUSY]      = (tx_state_q != StIdle);
    status[ST_TX_CNT +: 4]  = sat_cnt4(5'(tx_count));
    status[ST_RX_CNT +: 4]  = sat_cnt4(5'(rx_count));
  end

  // Read mux, combinational on paddr
  always_comb begin
    apb.prdata = '0;
    unique case (reg_sel)
      REG_DATA:   if (!rx_empty) apb.prdata = {24'h0, rx_rdata};
      REG_STATUS: apb.prdata = {16'h0, status};
      REG_BAUD:   apb.prdata = {16'h0, baud_q};
      REG_IRQ_EN: apb.prdata = {29'h0, irq_en_q};
      default:    apb.prdata = '0;
    endcase
  end

  // Level interrupt, registered one cycle behind its sources
  always_ff @(posedge pclk) begin
    if (!presetn) irq_q <= 1'b0;
    else irq_q <= (irq_en_q[IE_RX_NE] & ~rx_empty) | (irq_en_q[IE_TX_EMPTY] & tx_empty) |
                  (irq_en_q[IE_ERR] & (ovr_q | ferr_q));
  end

  assign irq    = irq_q;
  assign txd    = txd_q;
  assign txd_oe = 1'b1;

  // Pop at IDLE, or at the end of STOP so frames run back to back
  assign tx_pop = ~tx_empty &
                  ((tx_state_q == StIdle) || ((tx_state_q == StStop) && (tx_cnt_q == '0)));

  // TX FSM; the divisor is reloaded per bit so BAUD changes land on bit edges
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_sh_q    <= '0;
      tx_bit_q   <= '0;
      txd_q      <= 1'b1;
    end else begin
      unique case (tx_state_q)
        StIdle: begin
          txd_q <= 1'b1;
          if (tx_pop) begin
            tx_state_q <= StStart;
            tx_sh_q    <= tx_rdata;
            tx_cnt_q   <= baud_q;
            txd_q      <= 1'b0;
          end
        end
        StStart: begin
          if (tx_cnt_q == '0) begin
            tx_state_q <= StData;
            tx_cnt_q   <= baud_q;
            tx_bit_q   <= '0;
            txd_q      <= tx_sh_q[0];
            tx_sh_q    <= {1'b0, tx_sh_q[7:1]};
          end else begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end
        end
        StData: begin
          if (tx_cnt_q == '0) begin
            tx_cnt_q <= baud_q;
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= StStop;
              txd_q      <= 1'b1;
            end else begin
              tx_bit_q <= tx_bit_q + 3'd1;
              txd_q    <= tx_sh_q[0];
              tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end
        end
        StStop: begin
          if (tx_cnt_q == '0) begin
            if (tx_pop) begin
              tx_state_q <= StStart;
              tx_sh_q    <= tx_rdata;
              tx_cnt_q   <= baud_q;
              txd_q      <= 1'b0;
            end else begin
              tx_state_q <= StIdle;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end
        end
        default: tx_state_q <= StIdle;
      endcase
    end
  end

  // rxd synchroniser plus one history flop for falling-edge detection
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rxd;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  assign rx_half     = (17'(baud_q) + 17'd1) >> 1;
  assign rx_half_m1  = 16'(rx_half - 17'd1);
  assign rx_stop_smp = (rx_state_q == StStop) && (rx_cnt_q == '0);
  assign rx_push     = rx_stop_smp & rx_s2_q;
  assign ferr_set    = rx_stop_smp & ~rx_s2_q;
  assign ovr_set     = rx_push & rx_full & ~rx_pop_ok;

  // RX FSM: mid-bit sampling, back to IDLE straight after the stop sample
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_sh_q    <= '0;
      rx_bit_q   <= '0;
    end else begin
      unique case (rx_state_q)
        StIdle: begin
          if (rx_prev_q & ~rx_s2_q) begin
            rx_state_q <= StStart;
            rx_cnt_q   <= rx_half_m1;
          end
        end
        StStart: begin
          if (rx_cnt_q == '0) begin
            if (rx_s2_q) begin
              rx_state_q <= StIdle;
            end else begin
              rx_state_q <= StData;
              rx_cnt_q   <= baud_q;
              rx_bit_q   <= '0;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end
        end
        StData: begin
          if (rx_cnt_q == '0) begin
            rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
            rx_cnt_q <= baud_q;
            if (rx_bit_q == 3'd7) rx_state_q <= StStop;
            else rx_bit_q <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end
        end
        StStop: begin
          if (rx_cnt_q == '0) rx_state_q <= StIdle;
          else rx_cnt_q <= rx_cnt_q - 16'd1;
        end
        default: rx_state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_cape_apb_uart.sv
// Bench for cape_apb_uart: queue-based scoreboards for the TX and RX paths,
// register/flag checks, glitch rejection and reset mid-frame.
module tb_cape_apb_uart;
  localparam logic [7:0] A_DATA   = 8'h00;
  localparam logic [7:0] A_STATUS = 8'h04;
  localparam logic [7:0] A_BAUD   = 8'h08;
  localparam logic [7:0] A_IRQ_EN = 8'h0C;

  logic pclk = 1'b0;
  logic presetn = 1'b0;
  logic rxd = 1'b1;
  logic txd, txd_oe, irq;
  int   cyc = 0;

  int n_total = 0;
  int n_bad = 0;

  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  logic mon_en = 1'b1;
  logic b2b = 1'b0;
  int   prev_start = -1;
  int   mon_st;
  logic [7:0] mon_b;

  cape_apb_uart_if apb_if ();

  cape_apb_uart #(.FIFO_DEPTH(8), .BAUD_DIV_RST(541)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .apb     (apb_if),
    .rxd     (rxd),
    .txd     (txd),
    .txd_oe  (txd_oe),
    .irq     (irq)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge pclk);
    apb_if.psel = 1'b1; apb_if.penable = 1'b0; apb_if.pwrite = 1'b1;
    apb_if.paddr = a; apb_if.pwdata = d;
    @(negedge pclk);
    apb_if.penable = 1'b1;
    @(negedge pclk);
    apb_if.psel = 1'b0; apb_if.penable = 1'b0; apb_if.pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge pclk);
    apb_if.psel = 1'b1; apb_if.penable = 1'b0; apb_if.pwrite = 1'b0; apb_if.paddr = a;
    @(negedge pclk);
    apb_if.penable = 1'b1;
    #1 d = apb_if.prdata;
    @(negedge pclk);
    apb_if.psel = 1'b0; apb_if.penable = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge pclk);
  endtask

  // Drive one 8N1 frame at 16 cycles per bit
  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge pclk);
    rxd = 1'b0;
    repeat (16) @(negedge pclk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (16) @(negedge pclk);
    end
    rxd = stop;
    repeat (16) @(negedge pclk);
    rxd = 1'b1;
  endtask

  task automatic wait_tx_drain();
    int t;
    t = 0;
    while (tx_exp.size() != 0 && t < 3000) begin
      @(negedge pclk);
      t++;
    end
    check("tx_drain", tx_exp.size(), 0);
  endtask

  // TX monitor: decodes frames mid-bit and compares against the TX scoreboard
  initial begin : tx_mon
    forever begin
      @(negedge pclk);
      if (mon_en && txd === 1'b0) begin
        mon_st = cyc;
        if (b2b && prev_start >= 0) check("tx_gap", mon_st - prev_start, 160);
        prev_start = mon_st;
        repeat (7) @(negedge pclk);
        check("tx_start_bit", {31'h0, txd}, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge pclk);
          mon_b[i] = txd;
        end
        repeat (16) @(negedge pclk);
        check("tx_stop_bit", {31'h0, txd}, 1);
        check("tx_expected", {31'h0, tx_exp.size() != 0}, 1);
        if (tx_exp.size() != 0) check("tx_byte", {24'h0, mon_b}, {24'h0, tx_exp.pop_front()});
      end
    end
  end

  initial begin : main
    logic [31:0] d;
    int n, t, cnt;
    logic [7:0] v;
    apb_if.psel = 1'b0; apb_if.penable = 1'b0; apb_if.pwrite = 1'b0;
    apb_if.paddr = '0; apb_if.pwdata = '0;
    wait_cycles(4);
    presetn = 1'b1;

    // Reset values
    check("rst_txd", {31'h0, txd}, 1);
    check("rst_txd_oe", {31'h0, txd_oe}, 1);
    check("rst_irq", {31'h0, irq}, 0);
    apb_read(A_STATUS, d); check("rst_status", d, 32'h0000_0006);
    apb_read(A_BAUD, d);   check("rst_baud", d, 32'd541);
    apb_read(A_IRQ_EN, d); check("rst_irq_en", d, 32'h0);

    // Single TX frame; divisor write below the floor is clamped
    apb_write(A_BAUD, 32'd3);
    apb_read(A_BAUD, d); check("baud_clamp", d, 32'd15);
    tx_exp.push_back(8'hA5);
    apb_write(A_DATA, 32'hA5);
    t = 0;
    while (txd !== 1'b0 && t < 50) begin @(negedge pclk); t++; end
    n = 0;
    while (txd === 1'b0 && n < 100) begin n++; @(negedge pclk); end
    check("tx_start_len", n, 16);
    n = 0;
    while (txd === 1'b1 && n < 100) begin n++; @(negedge pclk); end
    check("tx_bit0_len", n, 16);
    wait_tx_drain();
    wait_cycles(20);

    // TX FIFO fill: the first byte leaves at once, 8 more fit, the 10th drops
    b2b = 1'b1; prev_start = -1; cnt = 0;
    for (int i = 0; i < 10; i++) begin
      v = 8'h10 + 8'(i * 7);
      if (i == 0) tx_exp.push_back(v);
      else if (cnt < 8) begin tx_exp.push_back(v); cnt++; end
      apb_write(A_DATA, {24'h0, v});
    end
    apb_read(A_STATUS, d); check("tx_fifo_full_status", d, 32'h0000_0845);
    wait_tx_drain();
    wait_cycles(20);
    b2b = 1'b0;

    // RX single frame with rx_not_empty interrupt
    apb_write(A_IRQ_EN, 32'h1);
    wait_cycles(2);
    check("irq_quiet", {31'h0, irq}, 0);
    rx_exp.push_back(8'h3C);
    send_rx(8'h3C, 1'b1);
    wait_cycles(4);
    apb_read(A_STATUS, d); check("rx_one_status", d, 32'h0000_1002);
    check("irq_rx", {31'h0, irq}, 1);
    apb_read(A_DATA, d); check("rx_data", d, {24'h0, rx_exp.pop_front()});
    apb_read(A_STATUS, d); check("rx_drained_status", d, 32'h0000_0006);
    wait_cycles(2);
    check("irq_drop", {31'h0, irq}, 0);

    // Overrun, framing error, then W1C of both
    for (int i = 0; i < 9; i++) begin
      v = 8'h80 + 8'(i * 3);
      if (rx_exp.size() < 8) rx_exp.push_back(v);
      send_rx(v, 1'b1);
    end
    wait_cycles(4);
    apb_read(A_STATUS, d); check("rx_overrun_status", d, 32'h0000_801A);
    send_rx(8'h5A, 1'b0);
    wait_cycles(20);
    apb_read(A_STATUS, d); check("rx_frame_err_status", d, 32'h0000_803A);
    apb_write(A_STATUS, 32'h30);
    apb_read(A_STATUS, d); check("w1c_status", d, 32'h0000_800A);
    for (int i = 0; i < 8; i++) begin
      apb_read(A_DATA, d);
      check("rx_fifo_data", d, {24'h0, rx_exp.pop_front()});
    end
    apb_read(A_STATUS, d); check("rx_empty_status", d, 32'h0000_0006);
    apb_read(A_DATA, d); check("rx_empty_read", d, 32'h0);

    // Short low glitch: false start, nothing pushed, no flags
    @(negedge pclk);
    rxd = 1'b0;
    wait_cycles(6);
    rxd = 1'b1;
    wait_cycles(40);
    apb_read(A_STATUS, d); check("glitch_status", d, 32'h0000_0006);

    // Reset in the middle of a TX frame
    mon_en = 1'b0;
    apb_write(A_DATA, 32'h55);
    apb_write(A_DATA, 32'h66);
    wait_cycles(40);
    apb_read(A_STATUS, d); check("mid_tx_status", d, 32'h0000_0144);
    @(negedge pclk);
    presetn = 1'b0;
    @(negedge pclk);
    check("rst_mid_txd", {31'h0, txd}, 1);
    presetn = 1'b1;
    apb_read(A_STATUS, d); check("rst_mid_status", d, 32'h0000_0006);
    apb_read(A_BAUD, d);   check("rst_mid_baud", d, 32'd541);
    check("rst_mid_irq", {31'h0, irq}, 0);
    wait_cycles(200);
    check("rst_mid_txd_idle", {31'h0, txd}, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
